// File: rtl/seq_always_pkg.sv
// Shared types for the seq_always pipeline stage: occupancy states and source-select codes.
package seq_always_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

  localparam int COUNT_W = 8;
  localparam int STALL_W = 4;

endpackage

// File: rtl/seq_always_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX until cleared.
module seq_always_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_always_stage15_pipe.sv
// One-entry valid/ready register stage with 4:1 source select, accept counter and stall counter.
// Optional out_parity output is enabled by defining SEQ_ALWAYS_PARITY_EN.
module seq_always_stage15_pipe
  import seq_always_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic [STALL_W-1:0] stall_cnt
`ifdef SEQ_ALWAYS_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  // The slot can take new data whenever it is empty or being drained this cycle.
  assign in_ready  = (state == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != EMPTY);

  // NOTE: default assignment first keeps this purely combinational (no latch).
  always_comb begin
    sel_data = in0;
    case (sel)
      SEL_IN0: sel_data = in0;
      SEL_IN1: sel_data = in1;
      SEL_IN2: sel_data = in2;
      SEL_IN3: sel_data = in3;
      default: sel_data = in0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        default: begin
          if (!out_ready)  state <= STALL;
          else if (accept) state <= FULL;
          else             state <= EMPTY;
        end
      endcase
      if (accept) begin
        out_data  <= sel_data;
        out_count <= out_count + COUNT_W'(1);
      end
    end
  end

`ifdef SEQ_ALWAYS_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         out_parity <= 1'b0;
    else if (accept) out_parity <= ^sel_data;
  end
`endif

  seq_always_sat_counter #(
    .W   (STALL_W),
    .MAX (STALL_MAX)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .clr   (out_ready || (state == EMPTY)),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_seq_always_stage15_pipe.sv
// Self-checking bench for seq_always_stage15_pipe: directed scenarios plus random traffic vs an occupancy model.
module tb_seq_always_stage15_pipe;

  localparam int WIDTH     = 4;
  localparam int STALL_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_count;
  logic [3:0]       stall_cnt;
`ifdef SEQ_ALWAYS_PARITY_EN
  logic             out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: is the slot occupied, what it holds, and the two counters.
  bit               m_full  = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_count = 0;
  int               m_stall = 0;

  seq_always_stage15_pipe #(
    .WIDTH     (WIDTH),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .stall_cnt (stall_cnt)
`ifdef SEQ_ALWAYS_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit ordy, input logic [1:0] s);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    sel       = s;
  endtask

  task automatic set_data(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs after the edge.
  task automatic tick();
    logic [WIDTH-1:0] src [4];
    bit exp_ready, acc, held;
    exp_ready = !m_full || out_ready;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    src[0] = in0; src[1] = in1; src[2] = in2; src[3] = in3;
    acc  = in_valid && exp_ready;
    held = m_full && !out_ready;
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_count = 0; m_stall = 0;
    end else begin
      if (acc) m_data = src[sel];
      m_stall = held ? ((m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX) : 0;
      m_full  = acc || held;
      m_count = (m_count + int'(acc)) % 256;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_count", 32'(out_count), 32'(m_count));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`ifdef SEQ_ALWAYS_PARITY_EN
    check("out_parity", 32'(out_parity), 32'(^m_data));
`endif
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    set_data(4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    #1;

    // Reset state
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Select: sel=10 picks in2
    set_data(4'h1, 4'h2, 4'h4, 4'h8);
    drive(1'b0, 1'b1, 1'b1, 2'b10);
    tick();
    check("select_data", 32'(out_data), 32'h4);
    check("select_count", 32'(out_count), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Throughput: four back-to-back accepts after a fresh reset
    drive(1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    set_data(4'h5, 4'h6, 4'h9, 4'hc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'(i));
      tick();
    end
    check("thru_last_data", 32'(out_data), 32'hc);
    check("thru_count", 32'(out_count), 32'd4);

    // Back-pressure: hold 4'h3 for 20 cycles, stall_cnt saturates
    drive(1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    set_data(4'h3, 4'ha, 4'hb, 4'hd);
    drive(1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    set_data(4'he, 4'he, 4'he, 4'he);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'(i));
      tick();
    end
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_data_hold", 32'(out_data), 32'h3);
    check("bp_stall_sat", 32'(stall_cnt), 32'd15);

    // Reset mid-STALL wins over a simultaneous accept
    drive(1'b1, 1'b1, 1'b1, 2'b01);
    tick();
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_count", 32'(out_count), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Simultaneous drain+accept after a short stall
    drive(1'b0, 1'b1, 1'b1, 2'b00);
    set_data(4'h7, 4'h0, 4'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'b11);
    set_data(4'h0, 4'h0, 4'h0, 4'hb);
    tick();
    check("drain_acc_valid", 32'(out_valid), 32'd1);
    check("drain_acc_data", 32'(out_data), 32'hb);
    check("drain_acc_stall", 32'(stall_cnt), 32'd0);

    // Wrap: 256 accepts bring out_count back to 0, one more gives 1
    drive(1'b1, 1'b0, 1'b1, 2'b00);
    tick();
    for (int i = 0; i < 256; i++) begin
      set_data(4'($urandom_range(15)), 4'($urandom_range(15)),
               4'($urandom_range(15)), 4'($urandom_range(15)));
      drive(1'b0, 1'b1, 1'b1, 2'($urandom_range(3)));
      tick();
    end
    check("wrap_zero", 32'(out_count), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    check("wrap_one", 32'(out_count), 32'd1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      set_data(4'($urandom_range(15)), 4'($urandom_range(15)),
               4'($urandom_range(15)), 4'($urandom_range(15)));
      drive(($urandom_range(39) == 0), 1'($urandom_range(1)),
            ($urandom_range(3) != 0), 2'($urandom_range(3)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_always_stage15_pipe.md
SEQ_ALWAYS_STAGE15_PIPE -- requirements
Module: seq_always_stage15_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of every data port.
REQ-002 SHALL have parameter STALL_MAX, default 15, saturation value of stall_cnt; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream presents a transaction.
REQ-006 SHALL have port in_ready, output, 1, block accepts the transaction this cycle.
REQ-007 SHALL have port sel, input, 2, source select.
REQ-008 SHALL have ports in0, in1, in2, in3, input, WIDTH each, candidate data.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a transaction.
REQ-010 SHALL have port out_ready, input, 1, downstream takes out_data this cycle.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-012 SHALL have port out_count, output, 8, count of accepted transactions, wraps 255->0.
REQ-013 SHALL have port stall_cnt, output, 4, consecutive back-pressure cycles, saturating.

Function
REQ-014 SHALL accept on in_valid && in_ready; in_ready = (state==EMPTY) || out_ready, combinational.
REQ-015 SHALL select on accept: sel 00->in0, 01->in1, 10->in2, 11->in3; registered to out_data, one-cycle latency.
REQ-016 SHALL implement states EMPTY, FULL, STALL from the package enum.
REQ-017 SHALL transition EMPTY->FULL on accept; otherwise stay EMPTY.
REQ-018 SHALL, in FULL/STALL: out_ready && accept -> FULL (new data loaded same edge); out_ready && !accept -> EMPTY; !out_ready -> STALL.
REQ-019 SHALL drive out_valid = (state != EMPTY); out_data SHALL stay stable while out_valid && !out_ready.
REQ-020 SHALL increment stall_cnt each cycle in STALL or entering STALL, saturate at STALL_MAX, clear to 0 on any cycle out_ready is high or state is EMPTY.
REQ-021 SHALL increment out_count by 1 per accept, modulo 256.
REQ-022 SHALL sustain one transaction per cycle when out_ready is held high.
REQ-023 SHALL ignore sel and in0..in3 when no accept occurs.

Reset
REQ-024 SHALL, on rst high at a clock edge: state EMPTY, out_valid 0, out_data 0, out_count 0, stall_cnt 0; in_ready 1 the cycle after.
REQ-025 SHALL let rst override a simultaneous accept; the in-flight transaction is dropped and not counted.

Configuration
REQ-026 SHALL, with SEQ_ALWAYS_PARITY_EN defined, add output out_parity (1 bit) = even parity (XOR-reduce) of out_data, registered with out_data, reset 0.
REQ-027 SHALL, without SEQ_ALWAYS_PARITY_EN, omit out_parity and its logic entirely; all other behaviour identical.

Structure
REQ-028 SHALL place the state enum (EMPTY, FULL, STALL) and sel encodings (SEL_IN0..SEL_IN3) in package seq_always_pkg.
REQ-029 SHALL implement stall_cnt in sub-module seq_always_sat_counter (inc, clr, saturate at parameter MAX).

Verification
REQ-030 SHALL cover reset: assert rst mid-STALL with out_valid=1 -> next cycle out_valid=0, out_count=0, stall_cnt=0.
REQ-031 SHALL cover select: out_ready=1, in0..in3=1,2,4,8, sel=2'b10 accepted -> out_data=4'h4 one cycle later, out_count=1.
REQ-032 SHALL cover back-pressure: FULL with out_data=4'h3, out_ready=0 for 20 cycles -> in_ready=0, out_data stays 4'h3, stall_cnt saturates at 15.
REQ-033 SHALL cover throughput: 4 back-to-back accepts sel=00,01,10,11 with out_ready=1 -> out_data in0,in1,in2,in3 on consecutive cycles, out_count=4.
REQ-034 SHALL cover wrap: 256 accepts -> out_count=0; one more -> 1.
REQ-035 SHALL cover simultaneous drain+accept: FULL, out_ready=1, in_valid=1 -> state stays FULL, new data loaded, stall_cnt=0.
